// File: rtl/m_axis_pkg.sv
// Shared types and helpers for the AXI4-Stream pixel transmitter.
//   tx_state_e    : framing FSM state (WAIT_SOF, STREAM)
//   pix_flags_t   : per-beat sideband flags {tuser, tlast}
//   col_width()   : bit width of the column counter for a given line length
//   row_width()   : bit width of the row counter for a given frame height
package m_axis_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        STREAM   = 1'b1
    } tx_state_e;

    // Sideband half of a FIFO entry; the data half is sized by the instantiating module.
    typedef struct packed {
        logic tuser;
        logic tlast;
    } pix_flags_t;

    localparam int unsigned FLAGS_W = 2;

    // Counters never collapse to zero width, even for a one-line frame.
    function automatic int unsigned col_width(input int unsigned image_width);
        return (image_width > 1) ? $clog2(image_width) : 1;
    endfunction

    function automatic int unsigned row_width(input int unsigned image_height);
        return (image_height > 1) ? $clog2(image_height) : 1;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
//   i_clk, i_aresetn : clock, asynchronous active-low reset (empties the FIFO)
//   i_wr_en/i_wr_data: write request; ignored while full
//   i_rd_en          : pop the head entry; ignored while empty
//   o_rd_data        : head entry (zero while empty)
//   o_full, o_empty  : registered status flags
//   o_level          : registered occupancy, 0..DEPTH
module axis_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_aresetn,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_d;

    assign w_push = i_wr_en & ~r_full;
    assign w_pop  = i_rd_en & ~r_empty;

    always_comb begin
        w_level_d = r_level;
        unique case ({w_push, w_pop})
            2'b10:   w_level_d = r_level + LVL_W'(1);
            2'b01:   w_level_d = r_level - LVL_W'(1);
            default: w_level_d = r_level;
        endcase
    end

    // Storage needs no reset: the empty flag masks stale contents.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_level <= w_level_d;
            r_full  <= (w_level_d == LVL_W'(DEPTH));
            r_empty <= (w_level_d == '0);
        end
    end

    // Head entry is stable until popped because writes never touch occupied slots.
    assign o_rd_data = r_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full    = r_full;
    assign o_empty   = r_empty;
    assign o_level   = r_level;

endmodule

// File: rtl/m_axis_pixel_tx.sv
// AXI4-Stream master for processed pixels leaving the gradient pipeline.
// Buffers a non-stallable pixel stream in a FIFO and adds AXIS framing.
//   i_clk, i_aresetn       : clock, asynchronous active-low reset
//   i_data, i_data_valid   : pixel stream from the core (cannot be stalled)
//   i_start_of_frame       : marks the first pixel of a frame (qualified by valid)
//   m_axis_tdata/tvalid/tready/tuser/tlast : AXIS master; tuser = SOF, tlast = end of line
//   o_overflow             : sticky, a pixel was dropped because the FIFO was full
//   o_fifo_level           : registered FIFO occupancy
module m_axis_pixel_tx
    import m_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned IMAGE_WIDTH  = 4096,
    parameter int unsigned IMAGE_HEIGHT = 4096,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_aresetn,
    input  logic [DATA_WIDTH-1:0]         i_data,
    input  logic                          i_data_valid,
    input  logic                          i_start_of_frame,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tuser,
    output logic                          m_axis_tlast,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

    localparam int unsigned COL_W   = col_width(IMAGE_WIDTH);
    localparam int unsigned ROW_W   = row_width(IMAGE_HEIGHT);
    localparam int unsigned ENTRY_W = FLAGS_W + DATA_WIDTH;
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMAGE_HEIGHT - 1);

    typedef struct packed {
        pix_flags_t            flags;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    tx_state_e        r_state;
    tx_state_e        w_state_d;
    logic [COL_W-1:0] r_col;
    logic [COL_W-1:0] w_col_d;
    logic [ROW_W-1:0] r_row;
    logic [ROW_W-1:0] w_row_d;
    logic             r_overflow;
    logic             w_overflow_d;

    logic             w_accept;
    logic [COL_W-1:0] w_wr_col;
    logic [ROW_W-1:0] w_wr_row;
    entry_t           w_wr_entry;
    entry_t           w_rd_entry;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state    <= WAIT_SOF;
            r_col      <= '0;
            r_row      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_col      <= w_col_d;
            r_row      <= w_row_d;
            r_overflow <= w_overflow_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_col_d      = r_col;
        w_row_d      = r_row;
        w_overflow_d = r_overflow;
        w_accept     = 1'b0;
        w_wr_col     = '0;
        w_wr_row     = '0;

        if (i_data_valid) begin
            if (w_full) begin
                // Dropping a pixel leaves a hole; abandon the frame until the next SOF.
                w_overflow_d = 1'b1;
                w_state_d    = WAIT_SOF;
                w_col_d      = '0;
                w_row_d      = '0;
            end else if (i_start_of_frame) begin
                // SOF (first or early) always restarts the frame at col 0 / row 0.
                w_accept  = 1'b1;
                w_state_d = STREAM;
            end else if (r_state == STREAM) begin
                w_accept = 1'b1;
                w_wr_col = r_col;
                w_wr_row = r_row;
            end
        end

        if (w_accept) begin
            if (w_wr_col == COL_MAX) begin
                w_col_d = '0;
                w_row_d = (w_wr_row == ROW_MAX) ? '0 : w_wr_row + ROW_W'(1);
            end else begin
                w_col_d = w_wr_col + COL_W'(1);
                w_row_d = w_wr_row;
            end
        end

        w_wr_entry.flags.tuser = (w_wr_col == '0) && (w_wr_row == '0);
        w_wr_entry.flags.tlast = (w_wr_col == COL_MAX);
        w_wr_entry.data        = i_data;
    end

    assign w_pop = ~w_empty & m_axis_tready;

    axis_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .i_wr_en   (w_accept),
        .i_wr_data (w_wr_entry),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_entry),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (o_fifo_level)
    );

    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = w_rd_entry.data;
    assign m_axis_tuser  = w_rd_entry.flags.tuser;
    assign m_axis_tlast  = w_rd_entry.flags.tlast;
    assign o_overflow    = r_overflow;

endmodule
